// File: rtl/cursor_ctrl.sv
// rtl/cursor_ctrl.sv - 4x4 grid cursor from five debounced push buttons
// Buttons are synchronised, debounced and edge-detected; press events move the cursor or raise a select request.
module cursor_ctrl #(
  parameter int DB_CNT = 250000,
  parameter bit WRAP   = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_up_n,
  input  logic       key_down_n,
  input  logic       key_left_n,
  input  logic       key_right_n,
  input  logic       key_sel_n,
  input  logic       enable,
  input  logic       sel_ack,
  output logic [1:0] xcoord,
  output logic [1:0] ycoord,
  output logic       sel_valid,
  output logic [3:0] sel_index
);

  localparam int NB = 5;
  localparam int B_UP = 0;
  localparam int B_DN = 1;
  localparam int B_LF = 2;
  localparam int B_RT = 3;
  localparam int B_SL = 4;
  localparam logic [19:0] DB_LAST = 20'(DB_CNT - 1);

  logic [NB-1:0] raw_n;
  logic [NB-1:0] sync1_q;
  logic [NB-1:0] sync2_q;
  logic [NB-1:0] stable_q;
  logic [NB-1:0] hist_q;
  logic [19:0]   cnt_q [NB];
  logic [NB-1:0] press;
  logic [NB-1:0] ev;

  logic [1:0] x_q, x_d;
  logic [1:0] y_q, y_d;
  logic       valid_q, valid_d;
  logic [3:0] index_q, index_d;

  assign raw_n = {key_sel_n, key_right_n, key_left_n, key_down_n, key_up_n};

  // Levels are active-low, so a press is a 1->0 transition of the debounced level.
  assign press = hist_q & ~stable_q;
  assign ev    = press & {NB{enable}};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q  <= '1;
      sync2_q  <= '1;
      stable_q <= '1;
      hist_q   <= '1;
      for (int i = 0; i < NB; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q <= raw_n;
      sync2_q <= sync1_q;
      hist_q  <= stable_q;
      for (int i = 0; i < NB; i++) begin
        if (sync2_q[i] == stable_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == DB_LAST) begin
          stable_q[i] <= sync2_q[i];
          cnt_q[i]    <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 20'd1;
        end
      end
    end
  end

  // Opposing events cancel; otherwise step once, wrapping or clamping at the edge.
  function automatic logic [1:0] step_coord(input logic [1:0] c, input logic dec, input logic inc);
    logic [1:0] r;
    r = c;
    if (inc && !dec) begin
      if (WRAP || c != 2'd3) r = c + 2'd1;
    end else if (dec && !inc) begin
      if (WRAP || c != 2'd0) r = c - 2'd1;
    end
    return r;
  endfunction

  always_comb begin
    x_d     = step_coord(x_q, ev[B_LF], ev[B_RT]);
    y_d     = step_coord(y_q, ev[B_UP], ev[B_DN]);
    valid_d = valid_q;
    index_d = index_q;
    if (sel_ack) begin
      valid_d = 1'b0;
    end else if (ev[B_SL] && !valid_q) begin
      valid_d = 1'b1;
      index_d = {y_q, x_q};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_q     <= '0;
      y_q     <= '0;
      valid_q <= 1'b0;
      index_q <= '0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      valid_q <= valid_d;
      index_q <= index_d;
    end
  end

  assign xcoord    = x_q;
  assign ycoord    = y_q;
  assign sel_valid = valid_q;
  assign sel_index = index_q;

endmodule

// File: tb/tb_cursor_ctrl.sv
// tb/tb_cursor_ctrl.sv - bench for cursor_ctrl, wrapping and clamping instances side by side
module tb_cursor_ctrl;

  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] keys_n = 5'b11111;  // {sel, right, left, down, up}
  logic       en = 1'b1;
  logic       ack = 1'b0;

  logic [1:0] xw, yw, xc, yc;
  logic       svw, svc;
  logic [3:0] iw, ic;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  cursor_ctrl #(.DB_CNT(DB), .WRAP(1'b1)) dut_w (
    .clk(clk), .reset(reset),
    .key_up_n(keys_n[0]), .key_down_n(keys_n[1]), .key_left_n(keys_n[2]),
    .key_right_n(keys_n[3]), .key_sel_n(keys_n[4]),
    .enable(en), .sel_ack(ack),
    .xcoord(xw), .ycoord(yw), .sel_valid(svw), .sel_index(iw)
  );

  cursor_ctrl #(.DB_CNT(DB), .WRAP(1'b0)) dut_c (
    .clk(clk), .reset(reset),
    .key_up_n(keys_n[0]), .key_down_n(keys_n[1]), .key_left_n(keys_n[2]),
    .key_right_n(keys_n[3]), .key_sel_n(keys_n[4]),
    .enable(en), .sel_ack(ack),
    .xcoord(xc), .ycoord(yc), .sel_valid(svc), .sel_index(ic)
  );

  // Reference model: raw-sample history per button, coordinates as plain integers.
  logic [15:0] mh [5];
  logic        ms [5];
  logic        mp [5];
  int          mx [2];
  int          my [2];
  logic        msv [2];
  int          midx [2];

  function automatic int mv(int c, int d, int wrap);
    int n;
    n = c + d;
    if (wrap != 0) return (n + 4) % 4;
    if (n < 0) return 0;
    if (n > 3) return 3;
    return n;
  endfunction

  task automatic model_reset();
    for (int b = 0; b < 5; b++) begin
      mh[b] = '1;
      ms[b] = 1'b1;
      mp[b] = 1'b0;
    end
    for (int w = 0; w < 2; w++) begin
      mx[w] = 0; my[w] = 0; msv[w] = 1'b0; midx[w] = 0;
    end
  endtask

  task automatic model_edge();
    int dx, dy;
    logic all_diff;
    dx = int'(mp[3]) - int'(mp[2]);
    dy = int'(mp[1]) - int'(mp[0]);
    for (int w = 0; w < 2; w++) begin
      if (ack) msv[w] = 1'b0;
      else if (en && mp[4] && !msv[w]) begin
        msv[w] = 1'b1;
        midx[w] = my[w] * 4 + mx[w];
      end
      if (en) begin
        mx[w] = mv(mx[w], dx, w);
        my[w] = mv(my[w], dy, w);
      end
    end
    // A level is accepted once DB consecutive synchronised samples all disagree with it.
    for (int b = 0; b < 5; b++) begin
      all_diff = 1'b1;
      for (int i = 1; i <= DB; i++) if (mh[b][i] == ms[b]) all_diff = 1'b0;
      if (all_diff) begin
        ms[b] = ~ms[b];
        mp[b] = (ms[b] == 1'b0);
      end else begin
        mp[b] = 1'b0;
      end
      mh[b] = {mh[b][14:0], keys_n[b]};
    end
  endtask

  task automatic cmp(string tag, logic [8:0] act, logic [8:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got {x,y,valid,index}=%h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_all(string tag);
    cmp({tag, "/wrap"},  {xw, yw, svw, iw}, {2'(mx[1]), 2'(my[1]), msv[1], 4'(midx[1])});
    cmp({tag, "/clamp"}, {xc, yc, svc, ic}, {2'(mx[0]), 2'(my[0]), msv[0], 4'(midx[0])});
  endtask

  task automatic check_val(string tag, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic step(string tag = "cycle");
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    model_reset();
    check_all("reset");
    check_val("reset_x_immediate", int'(xw), 0);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
  endtask

  typedef struct {
    logic [4:0] keys;
    logic       en;
    logic       ack;
    int xw, yw; logic svw; int iw;
    int xc, yc; logic svc; int ic;
  } vec_t;

  vec_t tbl [13];

  initial begin
    //            keys      en  ack  xw yw svw iw  xc yc svc ic
    tbl[0]  = '{5'b01000, 1, 0,  1, 0, 0, 0,   1, 0, 0, 0};
    tbl[1]  = '{5'b01010, 1, 0,  2, 1, 0, 0,   2, 1, 0, 0};
    tbl[2]  = '{5'b01110, 1, 0,  2, 2, 0, 0,   2, 2, 0, 0};
    tbl[3]  = '{5'b01001, 1, 0,  3, 1, 0, 0,   3, 1, 0, 0};
    tbl[4]  = '{5'b01000, 1, 0,  0, 1, 0, 0,   3, 1, 0, 0};
    tbl[5]  = '{5'b00001, 1, 0,  0, 0, 0, 0,   3, 0, 0, 0};
    tbl[6]  = '{5'b00001, 1, 0,  0, 3, 0, 0,   3, 0, 0, 0};
    tbl[7]  = '{5'b10000, 1, 0,  0, 3, 1, 12,  3, 0, 1, 3};
    tbl[8]  = '{5'b01000, 0, 0,  0, 3, 1, 12,  3, 0, 1, 3};
    tbl[9]  = '{5'b00100, 1, 0,  3, 3, 1, 12,  2, 0, 1, 3};
    tbl[10] = '{5'b10000, 1, 0,  3, 3, 1, 12,  2, 0, 1, 3};
    tbl[11] = '{5'b00000, 1, 1,  3, 3, 0, 12,  2, 0, 0, 3};
    tbl[12] = '{5'b10000, 1, 0,  3, 3, 1, 15,  2, 0, 1, 2};

    model_reset();
    do_reset();

    for (int k = 0; k < 13; k++) begin
      en = tbl[k].en;
      if (tbl[k].ack) begin
        ack = 1'b1; step("tbl_ack"); ack = 1'b0;
      end
      keys_n = ~tbl[k].keys;
      repeat (8) step("tbl_press");
      keys_n = '1;
      repeat (8) step("tbl_release");
      check_val($sformatf("tbl%0d_xw", k), int'(xw), tbl[k].xw);
      check_val($sformatf("tbl%0d_yw", k), int'(yw), tbl[k].yw);
      check_val($sformatf("tbl%0d_svw", k), int'(svw), int'(tbl[k].svw));
      check_val($sformatf("tbl%0d_iw", k), int'(iw), tbl[k].iw);
      check_val($sformatf("tbl%0d_xc", k), int'(xc), tbl[k].xc);
      check_val($sformatf("tbl%0d_yc", k), int'(yc), tbl[k].yc);
      check_val($sformatf("tbl%0d_svc", k), int'(svc), int'(tbl[k].svc));
      check_val($sformatf("tbl%0d_ic", k), int'(ic), tbl[k].ic);
    end
    en = 1'b1;

    // Press latency: event visible at edge DB+3, no repeat while held.
    do_reset();
    keys_n = 5'b10111;
    for (int e = 1; e <= 7; e++) begin
      step("latency");
      if (e == DB + 2) check_val("latency_before", int'(xw), 0);
      if (e == DB + 3) check_val("latency_at", int'(xw), 1);
    end
    repeat (6) step("hold");
    check_val("hold_no_repeat", int'(xw), 1);
    keys_n = '1;
    repeat (8) step("release");
    keys_n = 5'b10111;
    repeat (8) step("repress");
    check_val("repress_x", int'(xw), 2);
    keys_n = '1;
    repeat (8) step("release");

    // Bounce on down button never qualifies; a clean hold then moves once.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      keys_n[1] = ((i / 2) % 2) == 1;
      step("bounce");
    end
    keys_n[1] = 1'b1;
    repeat (8) step("bounce_settle");
    check_val("bounce_y", int'(yw), 0);
    keys_n[1] = 1'b0;
    repeat (10) step("down_hold");
    check_val("down_once", int'(yw), 1);
    keys_n[1] = 1'b1;
    repeat (8) step("down_release");

    // Accept and ack on the same edge: ack wins.
    do_reset();
    ack = 1'b1;
    keys_n = 5'b01111;
    repeat (8) step("sel_ack_same");
    ack = 1'b0;
    keys_n = '1;
    repeat (8) step("sel_release");
    check_val("accept_ack_same_edge", int'(svw), 0);

    // Enable raised while a press is already held: no event.
    do_reset();
    en = 1'b0;
    keys_n = 5'b10111;
    repeat (8) step("en_low_press");
    en = 1'b1;
    repeat (8) step("en_high_held");
    check_val("enable_rise_held", int'(xw), 0);
    keys_n = '1;
    repeat (8) step("en_release");

    // Reset mid-debounce; held button must re-qualify from scratch.
    keys_n = 5'b10111;
    repeat (8) step("pre_reset_move");
    keys_n = '1;
    repeat (8) step("pre_reset_release");
    check_val("pre_reset_x", int'(xw), 1);
    keys_n = 5'b10111;
    repeat (3) step("mid_debounce");
    do_reset();
    for (int e = 1; e <= 7; e++) begin
      step("post_reset");
      if (e == DB + 2) check_val("post_reset_before", int'(xw), 0);
      if (e == DB + 3) check_val("post_reset_at", int'(xw), 1);
    end
    keys_n = '1;
    repeat (8) step("post_reset_release");

    // Randomised stimulus against the model.
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 3) == 0) keys_n = 5'($urandom);
      en  = ($urandom_range(0, 7) != 0);
      ack = ($urandom_range(0, 15) == 0);
      repeat ($urandom_range(1, 10)) step("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cursor_ctrl.md
Name: cursor_ctrl

Overview:
Generates the 2-bit cursor column/row (xcoord, ycoord) consumed by the cursor overlay renderer on the 4x4 card grid, from five raw push buttons (up, down, left, right, select). Each button is synchronised, debounced and edge-detected. Movement wraps or clamps at the grid edges. A select press raises a held request carrying the card index, which the game logic clears with an acknowledge.

Parameters:
DB_CNT, 250000, consecutive stable cycles required to accept a button level change (5 ms at 50 MHz); must be >= 2; counter width 20 bits.
WRAP, 1, 1 = moves wrap at grid edges (3->0, 0->3); 0 = moves clamp at 0 and 3.

Ports:
clk  input  1  system clock; all state on rising edge
reset  input  1  asynchronous, active-low reset
key_up_n  input  1  raw up button, active-low, asynchronous to clk
key_down_n  input  1  raw down button, active-low
key_left_n  input  1  raw left button, active-low
key_right_n  input  1  raw right button, active-low
key_sel_n  input  1  raw select button, active-low
enable  input  1  1 = moves and selects accepted; 0 = press events discarded (debouncing continues)
sel_ack  input  1  game logic acknowledge; clears sel_valid
xcoord  output  2  cursor column 0..3, registered
ycoord  output  2  cursor row 0..3, registered
sel_valid  output  1  select request pending, registered
sel_index  output  4  {ycoord, xcoord} latched at accepted select, registered

Behaviour:
- Reset (reset=0, asynchronous): xcoord=0, ycoord=0, sel_valid=0, sel_index=0.
- Reset also clears internal state: sync flops=released (1), debounced levels=released, edge-history=released, debounce counters=0.
- Per button, 2-flop synchroniser: the output s2 reflects raw input after 2 edges.
- Per button, debounce counter:
  - if s2 == stable: cnt <= 0.
  - else if cnt == DB_CNT-1: stable <= s2, cnt <= 0.
  - else: cnt <= cnt+1.
  - Bounces shorter than DB_CNT cycles reset the count and never change stable.
- Press event: stable goes released->pressed, detected against a 1-cycle delayed copy. Exactly one event per accepted press. Release produces no event; holding does not repeat.
- Latency: with the pressed level first sampled at edge 1, stable flips at edge DB_CNT+2 and xcoord/ycoord/sel_valid update at edge DB_CNT+3.
- Moves (only when enable=1 in the event cycle):
  - left: x-1; right: x+1; up: y-1; down: y+1.
  - left and right events in the same cycle cancel (x unchanged); same for up and down.
  - A horizontal and a vertical event in the same cycle both apply.
  - Edge handling: WRAP=1 wraps modulo 4; WRAP=0 holds at 0 or 3.
- Moves are permitted while sel_valid=1; sel_index keeps its latched value.
- Select:
  - Accepted when enable=1 and sel_valid=0 at the event edge. Then sel_valid <= 1 and sel_index <= {ycoord, xcoord} using the pre-move coordinates of that same cycle.
  - A select event while sel_valid=1 is dropped, not queued.
- sel_ack=1 at an edge with sel_valid=1: sel_valid <= 0 at that edge. If an accept and an ack coincide, the ack wins and the select is dropped. sel_ack with sel_valid=0 is ignored.
- enable=0: all events discarded, outputs hold. Debounce state keeps tracking, so a button still held when enable rises generates no event.

Test Plan:
- Reset, DB_CNT=4, WRAP=1: key_right_n low with clean edge before edge 1 -> xcoord 0->1 at edge 7, unchanged for the rest of the hold; release then re-press -> xcoord=2.
- Bounce: key_down_n toggling every 2 cycles for 20 cycles, then settled high -> ycoord stays 0. Then held low 10 cycles -> ycoord=1 exactly once.
- Wrap/clamp: WRAP=1 with x=3 plus right press -> x=0, and y=0 plus up press -> y=3. WRAP=0: same stimulus -> x stays 3, y stays 0.
- Simultaneous: left+right+down pressed on the same edge from (x=1, y=1) -> x=1, y=2; up+right together -> x=2, y=1.
- Select handshake: at (x=2, y=3) press select -> sel_valid=1, sel_index=4'b1110. A second select and a right move while valid -> sel_index unchanged, x=3. sel_ack pulse -> sel_valid=0. Accept and ack on the same edge -> sel_valid=0.
- enable=0 during a right press -> xcoord unchanged. Raise enable while still held -> no move. reset asserted mid-debounce -> outputs 0 immediately; no event after release of reset while the button remains held until counter re-qualifies.
